// File: rtl/uart_cmd_engine.sv
// uart_cmd_engine: parses 4-byte command headers from UART RX, feeds payload
// to a selected compute unit, starts it and streams its result to UART TX.
module uart_cmd_engine #(
  parameter int datawidth_p = 8,
  parameter int num_units_p = 3,
  parameter int result_bytes_p = 4,
  parameter logic [datawidth_p-1:0] opcode_base_p = 8'h10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic [datawidth_p-1:0] rx_data_i,
  input  logic rx_valid_i,
  output logic rx_ready_o,
  output logic [datawidth_p-1:0] tx_data_o,
  output logic tx_valid_o,
  input  logic tx_ready_i,
  output logic [datawidth_p-1:0] op_data_o,
  output logic op_valid_o,
  input  logic op_ready_i,
  output logic [$clog2(num_units_p)-1:0] sel_o,
  output logic [num_units_p-1:0] start_o,
  input  logic [num_units_p-1:0] done_i,
  input  logic [num_units_p*result_bytes_p*datawidth_p-1:0] result_i,
  output logic [15:0] len_o
);

  localparam int SelW = $clog2(num_units_p);
  localparam int RW = result_bytes_p * datawidth_p;
  localparam int TxW = (result_bytes_p > 1) ? $clog2(result_bytes_p) : 1;
  localparam logic [TxW-1:0] TxLast = TxW'(result_bytes_p - 1);

  typedef enum logic [2:0] {
    StOpcode,
    StReserved,
    StLenLsb,
    StLenMsb,
    StPayload,
    StStart,
    StWait,
    StTx
  } state_t;

  state_t state, state_n;

  logic [SelW-1:0] sel;
  logic vld;
  logic [15:0] cnt;
  logic [RW-1:0] shreg;
  logic [TxW-1:0] tx_cnt;

  logic fire;
  logic tx_fire;
  logic done_sel;
  logic [datawidth_p-1:0] diff;
  logic op_ok;
  logic [15:0] len_full;
  logic [15:0] pay;
  logic [RW-1:0] slice;
  logic [num_units_p-1:0] one_hot;

  assign fire = rx_valid_i && rx_ready_o;
  assign tx_fire = tx_valid_o && tx_ready_i;
  assign done_sel = done_i[sel];
  assign diff = rx_data_i - opcode_base_p;
  assign op_ok = diff < datawidth_p'(num_units_p);
  assign len_full = {rx_data_i[7:0], len_o[7:0]};
  assign pay = (len_full < 16'd4) ? 16'd0 : len_full - 16'd4;
  assign slice = result_i[32'(sel) * RW +: RW];
  assign one_hot = num_units_p'(1) << sel;

  assign sel_o = sel;
  assign op_data_o = rx_data_i;
  assign start_o = (state == StStart) ? one_hot : '0;

  // RX is held off while reset is asserted, even though state reads idle.
  always_comb begin
    rx_ready_o = 1'b0;
    op_valid_o = 1'b0;
    unique case (state)
      StOpcode, StReserved, StLenLsb, StLenMsb: rx_ready_o = 1'b1;
      StPayload: begin
        if (vld) begin
          op_valid_o = rx_valid_i;
          rx_ready_o = op_ready_i;
        end else begin
          rx_ready_o = 1'b1;
        end
      end
      default: rx_ready_o = 1'b0;
    endcase
    if (!rst_ni) rx_ready_o = 1'b0;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      StOpcode: if (fire) state_n = StReserved;
      StReserved: if (fire) state_n = StLenLsb;
      StLenLsb: if (fire) state_n = StLenMsb;
      StLenMsb: begin
        if (fire) begin
          if (pay != 16'd0) state_n = StPayload;
          else if (vld) state_n = StStart;
          else state_n = StOpcode;
        end
      end
      StPayload: begin
        if (fire && cnt == 16'd1) begin
          state_n = vld ? StStart : StOpcode;
        end
      end
      StStart: state_n = StWait;
      StWait: if (done_sel) state_n = StTx;
      StTx: if (tx_fire && tx_cnt == TxLast) state_n = StOpcode;
      default: state_n = StOpcode;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= StOpcode;
    else state <= state_n;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sel <= '0;
      vld <= 1'b0;
      len_o <= '0;
      cnt <= '0;
      shreg <= '0;
      tx_data_o <= '0;
      tx_valid_o <= 1'b0;
      tx_cnt <= '0;
    end else begin
      unique case (state)
        StOpcode: begin
          if (fire) begin
            sel <= diff[SelW-1:0];
            vld <= op_ok;
          end
        end
        StLenLsb: if (fire) len_o[7:0] <= rx_data_i[7:0];
        StLenMsb: begin
          if (fire) begin
            len_o[15:8] <= rx_data_i[7:0];
            cnt <= pay;
          end
        end
        StPayload: if (fire) cnt <= cnt - 16'd1;
        StWait: begin
          if (done_sel) begin
            tx_data_o <= slice[RW-1 -: datawidth_p];
            shreg <= slice << datawidth_p;
            tx_valid_o <= 1'b1;
            tx_cnt <= '0;
          end
        end
        StTx: begin
          if (tx_fire) begin
            if (tx_cnt == TxLast) begin
              tx_valid_o <= 1'b0;
            end else begin
              tx_data_o <= shreg[RW-1 -: datawidth_p];
              shreg <= shreg << datawidth_p;
              tx_cnt <= tx_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_engine.sv
// tb_uart_cmd_engine: scoreboard bench for uart_cmd_engine.
// Expected TX and operand bytes are queued at stimulus time.
module tb_uart_cmd_engine;

  localparam int DW = 8;
  localparam int NU = 3;
  localparam int RB = 4;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic [DW-1:0] rx_data_i = '0;
  logic rx_valid_i = 1'b0;
  logic rx_ready_o;
  logic [DW-1:0] tx_data_o;
  logic tx_valid_o;
  logic tx_ready_i = 1'b1;
  logic [DW-1:0] op_data_o;
  logic op_valid_o;
  logic op_ready_i = 1'b1;
  logic [1:0] sel_o;
  logic [NU-1:0] start_o;
  logic [NU-1:0] done_i = '0;
  logic [NU*RB*DW-1:0] result_i = '0;
  logic [15:0] len_o;

  uart_cmd_engine dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .rx_data_i(rx_data_i),
    .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o),
    .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i),
    .op_data_o(op_data_o),
    .op_valid_o(op_valid_o),
    .op_ready_i(op_ready_i),
    .sel_o(sel_o),
    .start_o(start_o),
    .done_i(done_i),
    .result_i(result_i),
    .len_o(len_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] txq[$];
  logic [7:0] opq[$];
  int starts_seen = 0;
  int tx_hs = 0;
  logic bp = 1'b0;
  logic [1:0] exp_sel = '0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  initial begin
    logic pv, pr;
    logic [7:0] pd, e;
    pv = 1'b0;
    pr = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (rst_ni) begin
        if (start_o != '0) starts_seen++;
        if (op_valid_o && op_ready_i) begin
          if (opq.size() == 0) begin
            check("op_extra", opq.size(), 1);
          end else begin
            e = opq.pop_front();
            check("op_data", {24'd0, op_data_o}, {24'd0, e});
            check("op_sel", {30'd0, sel_o}, {30'd0, exp_sel});
          end
        end
        if (pv && !pr) begin
          check("tx_hold_valid", {31'd0, tx_valid_o}, 1);
          check("tx_hold_data", {24'd0, tx_data_o}, {24'd0, pd});
        end
        if (tx_valid_o && tx_ready_i) begin
          tx_hs++;
          if (txq.size() == 0) begin
            check("tx_extra", txq.size(), 1);
          end else begin
            e = txq.pop_front();
            check("tx_data", {24'd0, tx_data_o}, {24'd0, e});
          end
        end
      end
      pv = tx_valid_o && rst_ni;
      pr = tx_ready_i;
      pd = tx_data_o;
    end
  end

  // TX sink: ready always, or held low 5 cycles per byte under backpressure.
  initial begin
    int wc;
    wc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!bp) begin
        tx_ready_i = 1'b1;
        wc = 0;
      end else if (!tx_valid_o) begin
        tx_ready_i = 1'b0;
        wc = 0;
      end else if (tx_ready_i) begin
        tx_ready_i = 1'b0;
        wc = 1;
      end else begin
        wc++;
        tx_ready_i = (wc > 5);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(logic [7:0] b);
    logic ok;
    ok = 1'b0;
    rx_data_i = b;
    rx_valid_i = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = rx_ready_o;
      @(posedge clk);
      #1;
    end
    if (!ok) check("rx_timeout", {31'd0, ok}, 1);
    rx_valid_i = 1'b0;
  endtask

  task automatic send_hdr(logic [7:0] op, logic [15:0] len);
    send_byte(op);
    send_byte(8'h00);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
  endtask

  task automatic push_res(logic [31:0] r);
    for (int i = 3; i >= 0; i--) txq.push_back(r[i*8 +: 8]);
  endtask

  task automatic wait_start(logic [2:0] e);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = (start_o != '0);
    end
    check("start_seen", {31'd0, seen}, 1);
    check("start_val", {29'd0, start_o}, {29'd0, e});
    @(negedge clk);
    check("start_width", {29'd0, start_o}, 0);
  endtask

  task automatic wait_tx();
    logic empty;
    empty = 1'b0;
    for (int i = 0; i < 400 && !empty; i++) begin
      @(posedge clk);
      #2;
      empty = (txq.size() == 0);
    end
    check("tx_drained", {31'd0, empty}, 1);
    @(negedge clk);
    check("turnaround", {31'd0, rx_ready_o}, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s0, h0, k;
    logic [7:0] pb [3];
    logic [3:0] pat;

    // Reset state
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_rx_ready", {31'd0, rx_ready_o}, 0);
    check("rst_tx_valid", {31'd0, tx_valid_o}, 0);
    check("rst_tx_data", {24'd0, tx_data_o}, 0);
    check("rst_op_valid", {31'd0, op_valid_o}, 0);
    check("rst_start", {29'd0, start_o}, 0);
    check("rst_sel", {30'd0, sel_o}, 0);
    check("rst_len", {16'd0, len_o}, 0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    @(negedge clk);
    check("rel_rx_ready", {31'd0, rx_ready_o}, 1);
    @(posedge clk);
    #1;

    // Unit 0, no payload, done three cycles after start
    exp_sel = 2'd0;
    push_res(32'h12345678);
    send_hdr(8'h10, 16'd4);
    wait_start(3'b001);
    check("len4", {16'd0, len_o}, 4);
    repeat (3) @(posedge clk);
    #1;
    check("t1_tx_idle", {31'd0, tx_valid_o}, 0);
    result_i[0 +: 32] = 32'h12345678;
    done_i[0] = 1'b1;
    wait_tx();
    done_i = '0;

    // Payload pass-through with op_ready toggling 1,0,1,1
    exp_sel = 2'd1;
    opq.push_back(8'hAA);
    opq.push_back(8'hBB);
    opq.push_back(8'hCC);
    push_res(32'hCAFEF00D);
    send_hdr(8'h11, 16'd7);
    pb[0] = 8'hAA;
    pb[1] = 8'hBB;
    pb[2] = 8'hCC;
    pat = 4'b1101;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      rx_data_i = pb[k];
      rx_valid_i = 1'b1;
      op_ready_i = pat[i];
      @(negedge clk);
      check("rx_mirror", {31'd0, rx_ready_o}, {31'd0, op_ready_i});
      check("op_valid", {31'd0, op_valid_o}, 1);
      if (op_ready_i) k++;
      @(posedge clk);
      #1;
    end
    rx_valid_i = 1'b0;
    op_ready_i = 1'b1;
    check("t2_bytes", k, 3);
    @(negedge clk);
    check("start_u1", {29'd0, start_o}, 3'b010);
    @(negedge clk);
    check("start_u1_width", {29'd0, start_o}, 0);
    @(posedge clk);
    #1;
    done_i[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("other_done_ignored", {31'd0, tx_valid_o}, 0);
    result_i[32 +: 32] = 32'hCAFEF00D;
    done_i[1] = 1'b1;
    wait_tx();
    done_i = '0;

    // Unknown opcode is dropped, then a normal packet
    s0 = starts_seen;
    h0 = tx_hs;
    op_ready_i = 1'b0;
    send_hdr(8'h20, 16'd6);
    send_byte(8'h01);
    send_byte(8'h02);
    op_ready_i = 1'b1;
    @(negedge clk);
    check("bad_back_idle", {31'd0, rx_ready_o}, 1);
    check("bad_no_start", starts_seen, s0);
    check("bad_no_tx", tx_hs, h0);
    @(posedge clk);
    #1;
    exp_sel = 2'd0;
    push_res(32'h01020304);
    result_i[0 +: 32] = 32'h01020304;
    done_i[0] = 1'b1;
    send_hdr(8'h10, 16'd4);
    wait_start(3'b001);
    wait_tx();
    done_i = '0;

    // TX backpressure
    bp = 1'b1;
    exp_sel = 2'd1;
    h0 = tx_hs;
    push_res(32'hA1B2C3D4);
    result_i[32 +: 32] = 32'hA1B2C3D4;
    done_i[1] = 1'b1;
    send_hdr(8'h11, 16'd4);
    wait_start(3'b010);
    wait_tx();
    check("bp_count", tx_hs - h0, RB);
    bp = 1'b0;
    done_i = '0;

    // Reset after 2 of 3 payload bytes
    exp_sel = 2'd0;
    s0 = starts_seen;
    opq.push_back(8'h5A);
    opq.push_back(8'h6B);
    send_hdr(8'h10, 16'd7);
    send_byte(8'h5A);
    send_byte(8'h6B);
    rst_ni = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_start", {29'd0, start_o}, 0);
    check("mid_rst_tx_valid", {31'd0, tx_valid_o}, 0);
    check("mid_rst_rx_ready", {31'd0, rx_ready_o}, 0);
    check("mid_rst_len", {16'd0, len_o}, 0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", {31'd0, rx_ready_o}, 1);
    @(posedge clk);
    #1;

    // Short len with done already high
    exp_sel = 2'd2;
    push_res(32'h55AA33CC);
    result_i[64 +: 32] = 32'h55AA33CC;
    done_i[2] = 1'b1;
    send_hdr(8'h12, 16'd2);
    @(negedge clk);
    check("short_start", {29'd0, start_o}, 3'b100);
    check("short_len", {16'd0, len_o}, 2);
    @(negedge clk);
    check("short_tx_wait", {31'd0, tx_valid_o}, 0);
    @(negedge clk);
    check("short_tx_valid", {31'd0, tx_valid_o}, 1);
    check("short_tx_first", {24'd0, tx_data_o}, 32'h55);
    check("short_one_start", starts_seen, s0 + 1);
    wait_tx();
    done_i = '0;

    check("txq_left", txq.size(), 0);
    check("opq_left", opq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
